// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// One operation in flight at a time: IDLE (grant/accept) -> EXEC (drive ALU,
// capture result) -> RESP (hold response until consumed).
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_mode,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [ID_W-1:0] req0_tag,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_mode,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [ID_W-1:0] req1_tag,

  output logic            rsp0_valid,
  output logic [31:0]     rsp0_x,
  output logic            rsp0_zero,
  output logic [ID_W-1:0] rsp0_tag,
  input  logic            rsp0_ready,

  output logic            rsp1_valid,
  output logic [31:0]     rsp1_x,
  output logic            rsp1_zero,
  output logic [ID_W-1:0] rsp1_tag,
  input  logic            rsp1_ready,

  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_mode,
  input  logic [31:0]     alu_x,
  input  logic            alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_gnt;
  logic [3:0]      r_mode;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [ID_W-1:0] r_tag;

  logic [31:0]     r_rsp0_x;
  logic            r_rsp0_zero;
  logic [ID_W-1:0] r_rsp0_tag;
  logic [31:0]     r_rsp1_x;
  logic            r_rsp1_zero;
  logic [ID_W-1:0] r_rsp1_tag;

  logic            w_gnt1;
  logic            w_accept;
  logic            w_illegal;
  logic            w_rsp_done;
  logic [31:0]     w_res_x;
  logic            w_res_zero;

`ifdef ALU_ARB_RR_EN
  logic            r_last;

  // Round-robin pointer: remembers which requester won the last accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt1;
    end
  end

  assign w_gnt1 = req1_valid && (!req0_valid || !r_last);
`else
  assign w_gnt1 = req1_valid && !req0_valid;
`endif

  // Accept is gated with rst_n so no ready can be shown while reset is held.
  assign w_accept   = (r_state == S_IDLE) && rst_n && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_gnt1;
  assign req1_ready = w_accept && w_gnt1;

  assign alu_a    = (r_state == S_EXEC) ? r_a    : '0;
  assign alu_b    = (r_state == S_EXEC) ? r_b    : '0;
  assign alu_mode = (r_state == S_EXEC) ? r_mode : '0;

  assign w_illegal  = (r_mode == 4'b1010) || (r_mode == 4'b1110) || (r_mode == 4'b1111);
  assign w_res_x    = w_illegal ? '0 : alu_x;
  assign w_res_zero = w_illegal ? 1'b0 : alu_zero;

  assign rsp0_valid = (r_state == S_RESP) && !r_gnt;
  assign rsp1_valid = (r_state == S_RESP) && r_gnt;
  assign w_rsp_done = r_gnt ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  assign rsp0_x    = r_rsp0_x;
  assign rsp0_zero = r_rsp0_zero;
  assign rsp0_tag  = r_rsp0_tag;
  assign rsp1_x    = r_rsp1_x;
  assign rsp1_zero = r_rsp1_zero;
  assign rsp1_tag  = r_rsp1_tag;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (w_rsp_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the winning request's operands, tag and grant index on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= 1'b0;
      r_mode <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_tag  <= '0;
    end else if (w_accept) begin
      r_gnt  <= w_gnt1;
      r_mode <= w_gnt1 ? req1_mode : req0_mode;
      r_a    <= w_gnt1 ? req1_a    : req0_a;
      r_b    <= w_gnt1 ? req1_b    : req0_b;
      r_tag  <= w_gnt1 ? req1_tag  : req0_tag;
    end
  end

  // Capture the ALU result into the granted requester's response registers;
  // the other requester's registers keep their last response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_x    <= '0;
      r_rsp0_zero <= 1'b0;
      r_rsp0_tag  <= '0;
      r_rsp1_x    <= '0;
      r_rsp1_zero <= 1'b0;
      r_rsp1_tag  <= '0;
    end else if (r_state == S_EXEC) begin
      if (r_gnt) begin
        r_rsp1_x    <= w_res_x;
        r_rsp1_zero <= w_res_zero;
        r_rsp1_tag  <= r_tag;
      end else begin
        r_rsp0_x    <= w_res_x;
        r_rsp0_zero <= w_res_zero;
        r_rsp0_tag  <= r_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a transaction-level reference
// model and a behavioural stand-in for the shared ALU.
module tb_alu_arbiter;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [3:0]      req0_mode = '0, req1_mode = '0;
  logic [31:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [ID_W-1:0] req0_tag = '0, req1_tag = '0;
  logic            rsp0_valid, rsp1_valid;
  logic [31:0]     rsp0_x, rsp1_x;
  logic            rsp0_zero, rsp1_zero;
  logic [ID_W-1:0] rsp0_tag, rsp1_tag;
  logic            rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0]     alu_a, alu_b, alu_x;
  logic [3:0]      alu_mode;
  logic            alu_zero;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int              m_last;
  logic [31:0]     m_x[2];
  logic            m_zero[2];
  logic [ID_W-1:0] m_tag[2];

  alu_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_x(rsp0_x), .rsp0_zero(rsp0_zero),
    .rsp0_tag(rsp0_tag), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_x(rsp1_x), .rsp1_zero(rsp1_zero),
    .rsp1_tag(rsp1_tag), .rsp1_ready(rsp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_x(alu_x), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return ~a;
      4'd12:   return a & b;
      default: return a ^ ~b;
    endcase
  endfunction

  function automatic logic alu_zf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return (s == 32'd0);
  endfunction

  // Stand-in for the external combinational ALU
  always_comb begin
    alu_x    = alu_fn(alu_mode, alu_a, alu_b);
    alu_zero = alu_zf(alu_a, alu_b);
  end

  function automatic bit is_illegal(input logic [3:0] m);
    return (m == 4'b1010) || (m == 4'b1110) || (m == 4'b1111);
  endfunction

  function automatic int ref_winner(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_last = 1;
    for (int i = 0; i < 2; i++) begin
      m_x[i] = '0; m_zero[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One complete transaction: present request(s), check grant, ALU drive,
  // latency, response data, back-pressure stability, and release.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [3:0] md0, input logic [31:0] a0, input logic [31:0] b0, input logic [ID_W-1:0] t0,
                        input logic [3:0] md1, input logic [31:0] a1, input logic [31:0] b1, input logic [ID_W-1:0] t1,
                        input int dly, input bit poke, input string nm);
    int w, o;
    logic [3:0] md; logic [31:0] a, b, ex; logic ez; logic [ID_W-1:0] t;
    logic [31:0] ox; logic oz; logic [ID_W-1:0] ot;
    logic [31:0] qx; logic qz; logic [ID_W-1:0] qt;
    logic [1:0] exp_v;
    @(posedge clk); #1;
    req0_mode = md0; req0_a = a0; req0_b = b0; req0_tag = t0; req0_valid = v0;
    req1_mode = md1; req1_a = a1; req1_b = b1; req1_tag = t1; req1_valid = v1;
    #1;
    w = ref_winner(v0, v1);
    o = 1 - w;
    exp_v = (w == 1) ? 2'b10 : 2'b01;
    md = (w == 1) ? md1 : md0; a = (w == 1) ? a1 : a0;
    b  = (w == 1) ? b1 : b0;   t = (w == 1) ? t1 : t0;
    vectors++;
    if ({req1_ready, req0_ready} !== exp_v) begin
      errors++; $display("FAIL %s grant: ready1/0=%b%b expected winner %0d", nm, req1_ready, req0_ready, w);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = w;
    #1;
    vectors++;
    if ({alu_mode, alu_a, alu_b} !== {md, a, b}) begin
      errors++; $display("FAIL %s alu_drive: got mode=%h a=%h b=%h expected mode=%h a=%h b=%h", nm, alu_mode, alu_a, alu_b, md, a, b);
    end
    ex = is_illegal(md) ? 32'd0 : alu_fn(md, a, b);
    ez = is_illegal(md) ? 1'b0  : alu_zf(a, b);
    @(posedge clk); #1;
    ox = (w == 1) ? rsp1_x : rsp0_x;    oz = (w == 1) ? rsp1_zero : rsp0_zero; ot = (w == 1) ? rsp1_tag : rsp0_tag;
    qx = (o == 1) ? rsp1_x : rsp0_x;    qz = (o == 1) ? rsp1_zero : rsp0_zero; qt = (o == 1) ? rsp1_tag : rsp0_tag;
    vectors++;
    if ({rsp1_valid, rsp0_valid} !== exp_v) begin
      errors++; $display("FAIL %s latency: rsp_valid1/0=%b%b expected %b", nm, rsp1_valid, rsp0_valid, exp_v);
    end
    vectors++;
    if ({ox, oz, ot} !== {ex, ez, t}) begin
      errors++; $display("FAIL %s rsp_data: got x=%h zero=%b tag=%h expected x=%h zero=%b tag=%h", nm, ox, oz, ot, ex, ez, t);
    end
    vectors++;
    if ({qx, qz, qt} !== {m_x[o], m_zero[o], m_tag[o]}) begin
      errors++; $display("FAIL %s other_hold: got x=%h zero=%b tag=%h expected x=%h zero=%b tag=%h", nm, qx, qz, qt, m_x[o], m_zero[o], m_tag[o]);
    end
    vectors++;
    if ({alu_mode, alu_a, alu_b} !== 68'd0) begin
      errors++; $display("FAIL %s alu_idle: got mode=%h a=%h b=%h expected 0", nm, alu_mode, alu_a, alu_b);
    end
    m_x[w] = ex; m_zero[w] = ez; m_tag[w] = t;
    for (int i = 0; i < dly; i++) begin
      if (poke) begin req0_valid = 1'b1; req1_valid = 1'b1; end
      @(posedge clk); #1;
      ox = (w == 1) ? rsp1_x : rsp0_x; oz = (w == 1) ? rsp1_zero : rsp0_zero; ot = (w == 1) ? rsp1_tag : rsp0_tag;
      vectors++;
      if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, ox, oz, ot} !== {exp_v, 2'b00, ex, ez, t}) begin
        errors++;
        $display("FAIL %s hold: got v=%b%b rdy=%b%b x=%h zero=%b tag=%h expected v=%b rdy=00 x=%h zero=%b tag=%h",
                 nm, rsp1_valid, rsp0_valid, req1_ready, req0_ready, ox, oz, ot, exp_v, ex, ez, t);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = (w == 0); rsp1_ready = (w == 1);
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    vectors++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++; $display("FAIL %s release: rsp_valid1/0=%b%b expected 00", nm, rsp1_valid, rsp0_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #3;
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: got rdy=%b%b v=%b%b expected 0000", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
    end
    vectors++;
    if ({rsp0_x, rsp0_zero, rsp0_tag, rsp1_x, rsp1_zero, rsp1_tag} !== '0) begin
      errors++; $display("FAIL reset_rsp: got x0=%h x1=%h tags=%h/%h expected 0", rsp0_x, rsp1_x, rsp0_tag, rsp1_tag);
    end
    vectors++;
    if ({alu_mode, alu_a, alu_b} !== 68'd0) begin
      errors++; $display("FAIL reset_alu: got mode=%h a=%h b=%h expected 0", alu_mode, alu_a, alu_b);
    end
    req0_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_basic();
    do_txn(1'b1, 1'b0, 4'b0000, 32'd5, 32'd7, 4'd3, 4'd0, 32'd0, 32'd0, 4'd0, 0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 4'b1100, 32'hFFFF_FFFF, 32'd1, 4'd9, 5, 1'b1, "backpressure");
  endtask

  task automatic test_illegal();
    do_txn(1'b1, 1'b0, 4'b1110, 32'd1, 32'd1, 4'd5, 4'd0, 32'd0, 32'd0, 4'd0, 0, 1'b0, "illegal_1110");
    do_txn(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 4'b1010, 32'd6, 32'd3, 4'd2, 1, 1'b0, "illegal_1010");
    do_txn(1'b1, 1'b0, 4'b1111, 32'h80, 32'h7, 4'd7, 4'd0, 32'd0, 32'd0, 4'd0, 0, 1'b0, "illegal_1111");
  endtask

  task automatic test_reset_exec();
    bit seen;
    @(posedge clk); #1;
    req0_mode = 4'b0001; req0_a = 32'd9; req0_b = 32'd4; req0_tag = 4'd6; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1;
    vectors++;
    if (alu_mode !== 4'b0001) begin
      errors++; $display("FAIL rst_exec_pre: alu_mode=%h expected 1", alu_mode);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_mode, alu_a, alu_b, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 72'd0) begin
      errors++; $display("FAIL rst_exec_async: mode=%h a=%h b=%h v=%b%b rdy=%b%b expected 0", alu_mode, alu_a, alu_b, rsp0_valid, rsp1_valid, req0_ready, req1_ready);
    end
    vectors++;
    if ({rsp0_x, rsp1_x} !== 64'd0) begin
      errors++; $display("FAIL rst_exec_regs: x0=%h x1=%h expected 0", rsp0_x, rsp1_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_exec_discard: stray response seen=%b expected 0", seen);
    end
    do_txn(1'b1, 1'b0, 4'b0001, 32'd9, 32'd4, 4'd6, 4'd0, 32'd0, 32'd0, 4'd0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_arbitration();
    int got, w;
    do_reset();
    @(posedge clk); #1;
    req0_mode = 4'd0; req0_a = 32'd1; req0_b = 32'd2; req0_tag = 4'd1;
    req1_mode = 4'd1; req1_a = 32'd8; req1_b = 32'd3; req1_tag = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        w = ref_winner(1'b1, 1'b1);
        vectors++;
        if ({req1_ready, req0_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL arb_grant%0d: ready1/0=%b%b expected winner %0d", got, req1_ready, req0_ready, w);
        end
        m_last = w;
        got++;
      end
    end
    vectors++;
    if (got !== 4) begin
      errors++; $display("FAIL arb_count: got %0d grants expected 4", got);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    do_reset();
  endtask

  task automatic test_random();
    bit v0, v1;
    logic [3:0] m0, m1;
    logic [31:0] a0, b0, a1, b1;
    logic [ID_W-1:0] t0, t1;
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      m0 = 4'($urandom_range(0, 15)); m1 = 4'($urandom_range(0, 15));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      if ($urandom_range(0, 3) == 0) b0 = -a0;
      if ($urandom_range(0, 3) == 0) b1 = -a1;
      t0 = ID_W'($urandom_range(0, 15)); t1 = ID_W'($urandom_range(0, 15));
      do_txn(v0, v1, m0, a0, b0, t0, m1, a1, b1, t1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_illegal();
    test_basic();
    test_backpressure();
    test_reset_exec();
    test_arbitration();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ID_W, default 4, meaning the width of the request tag returned with each response.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have, for N in {0,1}, port reqN_valid  input  1  requester N has an operation pending.
REQ-005 The block SHALL have, for N in {0,1}, port reqN_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 The block SHALL have, for N in {0,1}, ports reqN_mode  input  4, reqN_a  input  32, reqN_b  input  32, reqN_tag  input  ID_W  operation code, operands and tag.
REQ-007 The block SHALL have, for N in {0,1}, ports rspN_valid  output  1, rspN_x  output  32, rspN_zero  output  1, rspN_tag  output  ID_W  result, flag and echoed tag.
REQ-008 The block SHALL have, for N in {0,1}, port rspN_ready  input  1  requester N consumes its response.
REQ-009 The block SHALL have ports alu_a  output  32, alu_b  output  32, alu_mode  output  4  driving the shared combinational ALU.
REQ-010 The block SHALL have ports alu_x  input  32, alu_zero  input  1  ALU result and flag, valid in the same cycle the ALU inputs are driven.

Function
REQ-011 The block SHALL implement FSM states IDLE, EXEC and RESP.
REQ-012 In IDLE with at least one reqN_valid, it SHALL grant exactly one requester, assert that reqN_ready for one cycle, latch mode/a/b/tag and the grant index, and move to EXEC.
REQ-013 reqN_ready SHALL be asserted only in IDLE and only for the granted requester; it SHALL NOT depend on rspN_ready.
REQ-014 In EXEC it SHALL drive alu_a/alu_b/alu_mode from the latched values, capture alu_x/alu_zero and the latched tag into response registers, and move to RESP.
REQ-015 Outside EXEC, alu_a, alu_b and alu_mode SHALL be 0.
REQ-016 In RESP it SHALL hold rspN_valid high for the granted requester only, with rspN_x/rspN_zero/rspN_tag stable, until rspN_ready is sampled high; it SHALL then return to IDLE.
REQ-017 Latency SHALL be: accept at edge t, rspN_valid high from cycle t+2; minimum issue interval 3 cycles.
REQ-018 Modes 4'b1010, 4'b1110 and 4'b1111 SHALL be illegal: the ALU result SHALL be ignored and the response SHALL be x=0, zero=0.
REQ-019 Requests arriving in EXEC or RESP SHALL wait; a requester deasserting valid before ready SHALL be dropped without error.
REQ-020 rspN_x/rspN_zero/rspN_tag for the non-granted requester SHALL hold their previous values, with rspN_valid low.

Reset
REQ-021 On rst_n low, the FSM SHALL enter IDLE immediately, regardless of clk.
REQ-022 All outputs, latched operands and response registers SHALL reset to 0, and the round-robin pointer SHALL reset to "last granted = 1".
REQ-023 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-024 With ALU_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not last granted wins, and the pointer updates on each accept.
REQ-025 Without ALU_ARB_RR_EN, requester 0 SHALL always win simultaneous requests, and no pointer register SHALL exist.

Verification
REQ-026 Scenario: after reset, req0 with mode=0000, a=5, b=7, tag=3 -> req0_ready for 1 cycle; alu_mode=0000 in EXEC; rsp0_valid at t+2 with x=12, zero=0, tag=3.
REQ-027 Scenario: req1 with mode=1100, a=32'hFFFFFFFF, b=1 -> rsp1 x=1, zero=1; rsp1_ready held low 5 cycles -> rsp1_valid and data stable, and no new accept until consumed.
REQ-028 Scenario: req0 and req1 both valid continuously, 4 operations, with ALU_ARB_RR_EN defined -> grants 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-029 Scenario: req0 with mode=1110, a=1, b=1 -> rsp0 x=0, zero=0.
REQ-030 Scenario: rst_n pulsed low during EXEC -> outputs 0 asynchronously, no rsp valid, FSM in IDLE; the next request completes normally.
